// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - pipeline-side signal bundle for the ID-stage hazard scoreboard
//
// Groups the ID/EX/MEM hazard inputs, the MDU issue inputs and all scoreboard outputs.
//   master : pipeline side (drives hazard inputs, consumes stall/writeback controls)
//   slave  : hazard_scoreboard side
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        IF_ID_useRs;
  logic        IF_ID_useRt;
  logic        IF_ID_isBranch;
  logic        IF_ID_isMdu;
  logic        ID_EX_regWrite;
  logic        ID_EX_memRead;
  logic [4:0]  ID_EX_dst;
  logic        EX_MEM_memRead;
  logic [4:0]  EX_MEM_dst;
  logic        mdu_start;
  logic [4:0]  mdu_start_dst;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic [1:0]  stall_cause;
  logic        mdu_busy;
  logic        mdu_wb_valid;
  logic [4:0]  mdu_wb_rd;
  logic        mdu_overlap_err;
  logic [31:0] stall_count;

  modport master (
    output id_valid, IF_ID_rs, IF_ID_rt, IF_ID_useRs, IF_ID_useRt, IF_ID_isBranch,
           IF_ID_isMdu, ID_EX_regWrite, ID_EX_memRead, ID_EX_dst, EX_MEM_memRead,
           EX_MEM_dst, mdu_start, mdu_start_dst,
    input  pc_write, if_id_write, id_ex_bubble, stall_cause, mdu_busy, mdu_wb_valid,
           mdu_wb_rd, mdu_overlap_err, stall_count
  );

  modport slave (
    input  id_valid, IF_ID_rs, IF_ID_rt, IF_ID_useRs, IF_ID_useRt, IF_ID_isBranch,
           IF_ID_isMdu, ID_EX_regWrite, ID_EX_memRead, ID_EX_dst, EX_MEM_memRead,
           EX_MEM_dst, mdu_start, mdu_start_dst,
    output pc_write, if_id_write, id_ex_bubble, stall_cause, mdu_busy, mdu_wb_valid,
           mdu_wb_rd, mdu_overlap_err, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard detection and MDU in-flight scoreboard
//
// Detects load-use, ID-resolved branch operand and MDU result hazards; on a hazard it
// freezes PC and IF/ID and bubbles ID/EX. Tracks one in-flight MDU op (countdown,
// destination, one-cycle writeback strobe) and flags overlapping MDU issues.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - hazard_scoreboard_if.slave (hazard inputs, MDU issue, stall/writeback outputs)
// Parameters:
//   MDU_LATENCY - cycles from MDU issue to writeback (2..15)
//   CNT_W       - countdown width, must hold MDU_LATENCY
// Optional macro:
//   HAZARD_PERF_EN - enables the saturating stall_count counter; otherwise stall_count=0
module hazard_scoreboard #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LATENCY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [4:0]       mdu_dst;
  logic             err;

  logic busy;
  logic last;
  logic lu;
  logic br;
  logic md;
  logic stall;
  logic [1:0] cause;

  function automatic logic src_match(input logic [4:0] r,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       use_rs,
                                     input logic       use_rt);
    return (r != 5'd0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  // Combinational outputs are held at their reset values while rst_n is low so a
  // reset mid-MDU can never emit a writeback strobe.
  always_comb begin
    busy  = rst_n && (cnt != '0);
    last  = rst_n && (cnt == ONE);
    lu    = bus.ID_EX_memRead &&
            src_match(bus.ID_EX_dst, bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_useRs, bus.IF_ID_useRt);
    br    = bus.IF_ID_isBranch &&
            ((bus.ID_EX_regWrite &&
              src_match(bus.ID_EX_dst, bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_useRs, bus.IF_ID_useRt)) ||
             (bus.EX_MEM_memRead &&
              src_match(bus.EX_MEM_dst, bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_useRs, bus.IF_ID_useRt)));
    md    = busy &&
            (src_match(mdu_dst, bus.IF_ID_rs, bus.IF_ID_rt, bus.IF_ID_useRs, bus.IF_ID_useRt) ||
             bus.IF_ID_isMdu);
    stall = rst_n && bus.id_valid && (lu || br || md);
    cause = 2'd0;
    if (stall) begin
      if (md)      cause = 2'd3;
      else if (lu) cause = 2'd1;
      else         cause = 2'd2;
    end
  end

  assign bus.pc_write        = !stall;
  assign bus.if_id_write     = !stall;
  assign bus.id_ex_bubble    = stall;
  assign bus.stall_cause     = cause;
  assign bus.mdu_busy        = busy;
  assign bus.mdu_wb_valid    = last;
  assign bus.mdu_wb_rd       = last ? mdu_dst : 5'd0;
  assign bus.mdu_overlap_err = err;

  // A start is accepted when idle or on the writeback cycle (back-to-back issue);
  // a start during any earlier countdown cycle is dropped and latches the error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      mdu_dst <= 5'd0;
      err     <= 1'b0;
    end else if ((cnt == '0) || (cnt == ONE)) begin
      if (bus.mdu_start) begin
        cnt     <= LAT;
        mdu_dst <= bus.mdu_start_dst;
      end else begin
        cnt     <= '0;
      end
    end else begin
      cnt <= cnt - ONE;
      if (bus.mdu_start) err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf <= 32'd0;
    end else if (stall && (perf != 32'hFFFF_FFFF)) begin
      perf <= perf + 32'd1;
    end
  end

  assign bus.stall_count = perf;
`else
  assign bus.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - scoreboard bench for hazard_scoreboard
module tb_hazard_scoreboard;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus ();

  hazard_scoreboard #(.MDU_LATENCY(LAT), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       is_branch;
    logic       is_mdu;
    logic       ex_regwrite;
    logic       ex_memread;
    logic [4:0] ex_dst;
    logic       mem_memread;
    logic [4:0] mem_dst;
    logic       start;
    logic [4:0] start_dst;
  } stim_t;

  typedef struct packed {
    logic        pc_write;
    logic        if_id_write;
    logic        bubble;
    logic [1:0]  cause;
    logic        busy;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        err;
    logic [31:0] cnt;
  } resp_t;

  resp_t exp_q[$];
  int    tag_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: one MDU op described by its issue cycle rather than a counter.
  int          cyc = 0;
  bit          have_op = 0;
  int          t0 = 0;
  logic [4:0]  op_dst = 0;
  logic        m_err = 0;
  logic [31:0] m_cnt = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic bit reads(input stim_t s, input logic [4:0] r);
    return (r != 0) && ((s.use_rs && r == s.rs) || (s.use_rt && r == s.rt));
  endfunction

  task automatic step(input stim_t s);
    resp_t e;
    int    el;
    bit    active, lu, br, md, st;
    rst_n                = s.rst_n;
    bus.id_valid         = s.id_valid;
    bus.IF_ID_rs         = s.rs;
    bus.IF_ID_rt         = s.rt;
    bus.IF_ID_useRs      = s.use_rs;
    bus.IF_ID_useRt      = s.use_rt;
    bus.IF_ID_isBranch   = s.is_branch;
    bus.IF_ID_isMdu      = s.is_mdu;
    bus.ID_EX_regWrite   = s.ex_regwrite;
    bus.ID_EX_memRead    = s.ex_memread;
    bus.ID_EX_dst        = s.ex_dst;
    bus.EX_MEM_memRead   = s.mem_memread;
    bus.EX_MEM_dst       = s.mem_dst;
    bus.mdu_start        = s.start;
    bus.mdu_start_dst    = s.start_dst;

    el     = cyc - t0;
    active = have_op && (el >= 0) && (el < LAT);
    lu = s.ex_memread && reads(s, s.ex_dst);
    br = s.is_branch && ((s.ex_regwrite && reads(s, s.ex_dst)) ||
                         (s.mem_memread && reads(s, s.mem_dst)));
    md = s.rst_n && active && (reads(s, op_dst) || s.is_mdu);
    st = s.rst_n && s.id_valid && (lu || br || md);
    e.pc_write    = !st;
    e.if_id_write = !st;
    e.bubble      = st;
    e.cause       = !st ? 2'd0 : md ? 2'd3 : lu ? 2'd1 : 2'd2;
    e.busy        = s.rst_n && active;
    e.wbv         = s.rst_n && active && (el == LAT - 1);
    e.wbrd        = e.wbv ? op_dst : 5'd0;
    e.err         = m_err;
`ifdef HAZARD_PERF_EN
    e.cnt         = m_cnt;
`else
    e.cnt         = 32'd0;
`endif
    exp_q.push_back(e);
    tag_q.push_back(cyc);

    if (!s.rst_n) begin
      have_op = 0;
      m_err   = 0;
      m_cnt   = 0;
    end else begin
      if (s.start) begin
        if (!active || el == LAT - 1) begin
          have_op = 1;
          t0      = cyc + 1;
          op_dst  = s.start_dst;
        end else begin
          m_err = 1;
        end
      end
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  task automatic mdu_go(input logic [4:0] d);
    stim_t s;
    s = idle();
    s.start = 1;
    s.start_dst = d;
    step(s);
  endtask

  // Monitor: every cycle the DUT presents a full response; compare against the queue.
  initial begin
    resp_t a, e;
    int    tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        a.pc_write    = bus.pc_write;
        a.if_id_write = bus.if_id_write;
        a.bubble      = bus.id_ex_bubble;
        a.cause       = bus.stall_cause;
        a.busy        = bus.mdu_busy;
        a.wbv         = bus.mdu_wb_valid;
        a.wbrd        = bus.mdu_wb_rd;
        a.err         = bus.mdu_overlap_err;
        a.cnt         = bus.stall_count;
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d actual pcw=%b ifw=%b bub=%b cause=%0d busy=%b wbv=%b rd=%0d err=%b cnt=%0d required pcw=%b ifw=%b bub=%b cause=%0d busy=%b wbv=%b rd=%0d err=%b cnt=%0d",
                   tag, a.pc_write, a.if_id_write, a.bubble, a.cause, a.busy, a.wbv, a.wbrd, a.err, a.cnt,
                   e.pc_write, e.if_id_write, e.bubble, e.cause, e.busy, e.wbv, e.wbrd, e.err, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    drain;
    rst_n = 1'b0;
    s = idle();
    s.rst_n = 1'b0;
    bus.id_valid = 0; bus.IF_ID_rs = 0; bus.IF_ID_rt = 0; bus.IF_ID_useRs = 0;
    bus.IF_ID_useRt = 0; bus.IF_ID_isBranch = 0; bus.IF_ID_isMdu = 0;
    bus.ID_EX_regWrite = 0; bus.ID_EX_memRead = 0; bus.ID_EX_dst = 0;
    bus.EX_MEM_memRead = 0; bus.EX_MEM_dst = 0; bus.mdu_start = 0; bus.mdu_start_dst = 0;
    repeat (2) @(posedge clk);
    #1;

    idles(1);

    // load-use on r5, then producer advances; same with r0 (never a hazard)
    s = idle(); s.id_valid = 1; s.ex_memread = 1; s.ex_dst = 5; s.rs = 5; s.use_rs = 1;
    step(s);
    s.ex_memread = 0; step(s);
    s = idle(); s.id_valid = 1; s.ex_memread = 1; s.ex_dst = 0; s.rs = 0; s.use_rs = 1;
    step(s);

    // branch on r7: ALU producer in EX, then load in MEM, then clear
    s = idle(); s.id_valid = 1; s.is_branch = 1; s.rt = 7; s.use_rt = 1;
    s.ex_regwrite = 1; s.ex_dst = 7; step(s);
    s.ex_regwrite = 0; s.mem_memread = 1; s.mem_dst = 7; step(s);
    s.mem_memread = 0; step(s);

    // MDU RAW on r9
    mdu_go(9);
    s = idle(); s.id_valid = 1; s.rs = 9; s.use_rs = 1;
    repeat (6) step(s);

    // back-to-back: second start on the writeback cycle
    mdu_go(9); idles(3); mdu_go(10); idles(5);

    // overlap: start while three cycles remain, then reset clears the error
    mdu_go(11); idles(1); mdu_go(12); idles(5);
    s = idle(); s.rst_n = 0; step(s);
    idles(1);

    // reset while two cycles remain: no strobe afterwards
    mdu_go(13); idles(2);
    s = idle(); s.rst_n = 0; step(s);
    idles(4);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s.rst_n       = ($urandom_range(0, 59) != 0);
      s.id_valid    = ($urandom_range(0, 3) != 0);
      s.rs          = 5'($urandom_range(0, 3));
      s.rt          = 5'($urandom_range(0, 3));
      s.use_rs      = 1'($urandom);
      s.use_rt      = 1'($urandom);
      s.is_branch   = ($urandom_range(0, 3) == 0);
      s.is_mdu      = ($urandom_range(0, 5) == 0);
      s.ex_regwrite = 1'($urandom);
      s.ex_memread  = ($urandom_range(0, 3) == 0);
      s.ex_dst      = 5'($urandom_range(0, 3));
      s.mem_memread = ($urandom_range(0, 3) == 0);
      s.mem_dst     = 5'($urandom_range(0, 3));
      s.start       = ($urandom_range(0, 5) == 0);
      s.start_dst   = 5'($urandom_range(0, 3));
      step(s);
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 4) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- ID-stage counterpart to EX-stage bypassing in the 5-stage pipeline.
- Detects hazards that bypassing cannot resolve:
  - load-use;
  - branch operands resolved in ID;
  - results of the multi-cycle multiply/divide unit (MDU).
- On a hazard it freezes PC and IF/ID and injects a bubble into ID/EX.
- Owns the MDU in-flight scoreboard: latency countdown, destination tracking, writeback strobe.

Parameters:
- MDU_LATENCY, 4: cycles from MDU issue to result writeback; legal range 2..15.
- CNT_W, 4: width of MDU countdown counter; must hold MDU_LATENCY.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- id_valid  input  1  IF/ID holds a valid instruction
- IF_ID_rs  input  5  source register 1 of ID instruction
- IF_ID_rt  input  5  source register 2 of ID instruction
- IF_ID_useRs  input  1  ID instruction reads rs
- IF_ID_useRt  input  1  ID instruction reads rt
- IF_ID_isBranch  input  1  ID instruction is a branch compared in ID
- IF_ID_isMdu  input  1  ID instruction is an MDU op
- ID_EX_regWrite  input  1  EX-stage instruction writes a register
- ID_EX_memRead  input  1  EX-stage instruction is a load
- ID_EX_dst  input  5  EX-stage destination register
- EX_MEM_memRead  input  1  MEM-stage instruction is a load
- EX_MEM_dst  input  5  MEM-stage destination register
- mdu_start  input  1  MDU op enters EX this cycle
- mdu_start_dst  input  5  destination of starting MDU op
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID update enable
- id_ex_bubble  output  1  zero ID/EX control fields
- stall_cause  output  2  0 none, 1 load-use, 2 branch operand, 3 MDU
- mdu_busy  output  1  MDU op in flight
- mdu_wb_valid  output  1  one-cycle MDU writeback strobe
- mdu_wb_rd  output  5  MDU writeback destination
- mdu_overlap_err  output  1  sticky protocol-violation flag
- stall_count  output  32  stall-cycle counter (see Optional Feature)

Behaviour:
- State: cnt[CNT_W-1:0], mdu_dst[4:0], err flag, perf counter; all cleared by rst_n=0 at the clock edge.
- Outputs in reset:
  - pc_write=1, if_id_write=1, id_ex_bubble=0, stall_cause=0;
  - mdu_busy=0, mdu_wb_valid=0, mdu_wb_rd=0, mdu_overlap_err=0, stall_count=0.
- match(r) = r!=0 && ((IF_ID_useRs && r==IF_ID_rs) || (IF_ID_useRt && r==IF_ID_rt)).
- Hazard terms, all combinational from inputs and current state, evaluated only when id_valid=1:
  - LU: ID_EX_memRead && match(ID_EX_dst).
  - BR: IF_ID_isBranch && ((ID_EX_regWrite && match(ID_EX_dst)) || (EX_MEM_memRead && match(EX_MEM_dst))).
  - MD: mdu_busy && (match(mdu_dst) || IF_ID_isMdu).
- stall = LU|BR|MD. While stall: pc_write=0, if_id_write=0, id_ex_bubble=1.
- stall_cause priority: MD=3 > LU=1 > BR=2; 0 when no stall.
- MDU countdown:
  - mdu_busy = (cnt!=0).
  - mdu_start with cnt==0: cnt<=MDU_LATENCY, mdu_dst<=mdu_start_dst.
  - cnt>0: cnt decrements by 1 per cycle.
  - cnt==1: mdu_wb_valid=1 and mdu_wb_rd=mdu_dst, combinational, exactly one cycle.
  - Next cycle cnt==0, busy drops; a stalled dependent proceeds that cycle.
- Back-to-back: mdu_start in the same cycle cnt==1 is legal. The current writeback still fires, then cnt<=MDU_LATENCY and mdu_dst<=new dst. No idle gap.
- mdu_start while cnt>1 is a violation:
  - the start is ignored;
  - mdu_overlap_err sets and stays set until reset.
- mdu_dst==0: countdown and strobe proceed normally, mdu_wb_rd=0; no RAW stall generated.
- Stall duration:
  - LU and BR-EX resolve in 1 cycle as the producer advances.
  - BR with a MEM-stage load takes up to 2 cycles total.
  - MD holds until busy drops.
- Reset mid-MDU: countdown discarded, no writeback strobe emitted.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_count increments on every cycle with stall=1;
  - saturates at 32'hFFFF_FFFF;
  - cleared by reset.
- Not defined: stall_count tied to 0 and no counter flops synthesized. Port list unchanged.

Test Plan:
- Load-use: ID_EX_memRead=1, ID_EX_dst=5, IF_ID_rs=5, useRs=1 -> exactly 1 cycle with pc_write=0, id_ex_bubble=1, stall_cause=1. Repeat with dst=0 -> no stall.
- Branch after ALU then load: IF_ID_isBranch=1, rt=7.
  - Cycle 0: ID_EX_regWrite=1, dst=7 -> stall, cause 2.
  - Cycle 1: EX_MEM_memRead=1, dst=7 -> stall, cause 2.
  - Cycle 2: no match -> no stall.
  - Total 2 stall cycles.
- MDU RAW with MDU_LATENCY=4: mdu_start, dst=9, then ID instruction reads r9.
  - Stall cause 3 while busy.
  - mdu_wb_valid=1 with rd=9 on the 4th cycle after start.
  - Stall released the following cycle.
- Back-to-back MDU: second mdu_start on the cnt==1 cycle, dst=10.
  - Writeback strobe for r9, then a strobe for r10 four cycles later.
  - mdu_overlap_err stays 0.
  - Start on a cnt==3 cycle instead -> start ignored, mdu_overlap_err=1 until rst_n.
- Reset: rst_n=0 for one edge while cnt=2 -> next cycle mdu_busy=0, no strobe, all outputs at reset values.
- HAZARD_PERF_EN: 3 load-use stalls plus 4 MDU stall cycles -> stall_count=7. Macro undefined -> stall_count=0.
